// File: rtl/cpu_ifetch_queue.sv
// Decoupling instruction queue between fetch and decode: a small circular buffer
// of (PC, instruction) pairs with a synchronous flush for redirects.

package rapid_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOOP_INSTRUCTION = 32'h0000_0013;
endpackage

module cpu_ifetch_queue
    import rapid_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_if_valid,
    input  logic [XLEN-1:0]            i_if_pc,
    input  logic [XLEN-1:0]            i_if_instruction,
    output logic                       o_if_ready,
    output logic                       o_id_valid,
    output logic [XLEN-1:0]            o_id_pc,
    output logic [XLEN-1:0]            o_id_instruction,
    input  logic                       i_id_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [XLEN-1:0]  pc_mem_r    [DEPTH];
    logic [XLEN-1:0]  instr_mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic not_full_s;
    logic not_empty_s;
    logic push_s;
    logic pop_s;

    // Handshake decode: ready/valid look only at registered occupancy, plus the flush kill.
    always_comb begin
        not_full_s  = (count_r != CNT_W'(DEPTH));
        not_empty_s = (count_r != {CNT_W{1'b0}});
        o_if_ready  = not_full_s && !i_flush;
        o_id_valid  = not_empty_s && !i_flush;
        push_s      = i_if_valid && o_if_ready;
        pop_s       = o_id_valid && i_id_ready;
        o_count     = count_r;
    end

    // Head presentation: invalid head shows the fetch bubble (pc 0, NOOP).
    always_comb begin
        o_id_pc          = {XLEN{1'b0}};
        o_id_instruction = NOOP_INSTRUCTION;
        if (o_id_valid) begin
            o_id_pc          = pc_mem_r[head_r];
            o_id_instruction = instr_mem_r[head_r];
        end else begin
            o_id_pc          = {XLEN{1'b0}};
            o_id_instruction = NOOP_INSTRUCTION;
        end
    end

    // Entry storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            pc_mem_r[tail_r]    <= i_if_pc;
            instr_mem_r[tail_r] <= i_if_instruction;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ifetch_queue.sv
// Directed self-checking bench for cpu_ifetch_queue (DEPTH = 4).

module tb_cpu_ifetch_queue;
    import rapid_pkg::*;

    localparam logic [31:0] NOOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_flush;
    logic        i_if_valid;
    logic [31:0] i_if_pc;
    logic [31:0] i_if_instruction;
    logic        o_if_ready;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_instruction;
    logic        i_id_ready;
    logic [2:0]  o_count;

    int tests_run    = 0;
    int tests_failed = 0;

    cpu_ifetch_queue #(.DEPTH(4)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_flush          (i_flush),
        .i_if_valid       (i_if_valid),
        .i_if_pc          (i_if_pc),
        .i_if_instruction (i_if_instruction),
        .o_if_ready       (o_if_ready),
        .o_id_valid       (o_id_valid),
        .o_id_pc          (o_id_pc),
        .o_id_instruction (o_id_instruction),
        .i_id_ready       (i_id_ready),
        .o_count          (o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[23:0], 8'h33};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
        i_if_valid       = v;
        i_if_pc          = pc;
        i_if_instruction = v ? ins(pc) : NOOP;
        i_id_ready       = rdy;
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_flush = 1'b0; i_id_ready = 1'b0;
        i_if_valid = 1'b0; i_if_pc = 32'h0; i_if_instruction = NOOP;
        #2;
        tests_run++; if (o_id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", o_id_valid); end
        tests_run++; if (o_id_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want 0", o_id_pc); end
        tests_run++; if (o_id_instruction !== NOOP) begin tests_failed++; $display("FAIL reset_instr got %h want %h", o_id_instruction, NOOP); end
        tests_run++; if (o_if_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %0b want 1", o_if_ready); end
        tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", o_count); end
        i_reset = 1'b0;
        step();
    endtask

    task automatic test_push();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4*i), 1'b0);
            step();
            tests_run++; if (o_count !== 3'(i+1)) begin tests_failed++; $display("FAIL push_count got %0d want %0d", o_count, i+1); end
            tests_run++; if (o_id_pc !== 32'h100 || o_id_valid !== 1'b1) begin tests_failed++; $display("FAIL push_head got %h/%0b want 100/1", o_id_pc, o_id_valid); end
            tests_run++; if (o_if_ready !== 1'b1) begin tests_failed++; $display("FAIL push_ready got %0b want 1", o_if_ready); end
        end
        tests_run++; if (o_id_instruction !== ins(32'h100)) begin tests_failed++; $display("FAIL push_instr got %h want %h", o_id_instruction, ins(32'h100)); end
    endtask

    task automatic test_full();
        drive(1'b1, 32'h10C, 1'b0);
        step();
        tests_run++; if (o_count !== 3'd4) begin tests_failed++; $display("FAIL full_count got %0d want 4", o_count); end
        tests_run++; if (o_if_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready got %0b want 0", o_if_ready); end
        drive(1'b1, 32'h110, 1'b0);
        step();
        tests_run++; if (o_count !== 3'd4) begin tests_failed++; $display("FAIL full_drop_count got %0d want 4", o_count); end
        drive(1'b0, 32'h0, 1'b1);
        tests_run++; if (o_if_ready !== 1'b0) begin tests_failed++; $display("FAIL full_pop_ready got %0b want 0", o_if_ready); end
        step();
        tests_run++; if (o_id_pc !== 32'h104) begin tests_failed++; $display("FAIL full_pop_head got %h want 104", o_id_pc); end
        tests_run++; if (o_if_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_rise got %0b want 1", o_if_ready); end
        tests_run++; if (o_count !== 3'd3) begin tests_failed++; $display("FAIL full_pop_count got %0d want 3", o_count); end
        step();
        tests_run++; if (o_id_pc !== 32'h108 || o_count !== 3'd2) begin tests_failed++; $display("FAIL full_pop2 got %h/%0d want 108/2", o_id_pc, o_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h110 + 32'(4*i), 1'b1);
            tests_run++; if (o_id_pc !== 32'h108 + 32'(4*i) || o_id_instruction !== ins(32'h108 + 32'(4*i))) begin
                tests_failed++; $display("FAIL b2b_head got %h want %h", o_id_pc, 32'h108 + 32'(4*i));
            end
            step();
            tests_run++; if (o_count !== 3'd2) begin tests_failed++; $display("FAIL b2b_count got %0d want 2", o_count); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            tests_run++; if (o_id_pc !== 32'h130 + 32'(4*i)) begin tests_failed++; $display("FAIL drain_head got %h want %h", o_id_pc, 32'h130 + 32'(4*i)); end
            step();
        end
        tests_run++; if (o_id_valid !== 1'b0 || o_id_pc !== 32'h0 || o_id_instruction !== NOOP) begin
            tests_failed++; $display("FAIL empty_bubble got %0b/%h/%h want 0/0/%h", o_id_valid, o_id_pc, o_id_instruction, NOOP);
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] exp_q[$];
        int seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8 && i % 2 == 0) drive(1'b1, 32'h200 + 32'(2*i), 1'b1);
            else drive(1'b0, 32'h0, 1'b1);
            if (o_id_valid) begin
                seen++;
                tests_run++;
                if (exp_q.size() == 0 || o_id_pc !== exp_q[0] || o_id_instruction === NOOP) begin
                    tests_failed++; $display("FAIL bubble_order got %h/%h want %h", o_id_pc, o_id_instruction, exp_q.size() ? exp_q[0] : 32'hx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (i_if_valid && o_if_ready) exp_q.push_back(i_if_pc);
            step();
        end
        tests_run++; if (seen != 4 || exp_q.size() != 0) begin tests_failed++; $display("FAIL bubble_total got %0d want 4", seen); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4*i), 1'b0);
            step();
        end
        tests_run++; if (o_count !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_count got %0d want 3", o_count); end
        i_flush = 1'b1;
        drive(1'b1, 32'h30C, 1'b1);
        tests_run++; if (o_id_valid !== 1'b0 || o_if_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_cycle got v%0b r%0b want v0 r0", o_id_valid, o_if_ready); end
        tests_run++; if (o_id_instruction !== NOOP || o_id_pc !== 32'h0) begin tests_failed++; $display("FAIL flush_cycle_head got %h/%h want 0/%h", o_id_pc, o_id_instruction, NOOP); end
        step();
        i_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        tests_run++; if (o_count !== 3'd0 || o_id_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_after got %0d/%0b want 0/0", o_count, o_id_valid); end
        tests_run++; if (o_id_instruction !== NOOP) begin tests_failed++; $display("FAIL flush_after_instr got %h want %h", o_id_instruction, NOOP); end
        drive(1'b1, 32'h400, 1'b0);
        step();
        tests_run++; if (o_id_pc !== 32'h400 || o_count !== 3'd1) begin tests_failed++; $display("FAIL flush_refill got %h/%0d want 400/1", o_id_pc, o_count); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h404, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        tests_run++; if (o_count !== 3'd2) begin tests_failed++; $display("FAIL areset_pre got %0d want 2", o_count); end
        #1 i_reset = 1'b1;
        #1;
        tests_run++; if (o_count !== 3'd0 || o_id_valid !== 1'b0 || o_if_ready !== 1'b1) begin
            tests_failed++; $display("FAIL areset_now got c%0d v%0b r%0b want c0 v0 r1", o_count, o_id_valid, o_if_ready);
        end
        tests_run++; if (o_id_pc !== 32'h0 || o_id_instruction !== NOOP) begin tests_failed++; $display("FAIL areset_head got %h/%h want 0/%h", o_id_pc, o_id_instruction, NOOP); end
        i_reset = 1'b0;
        drive(1'b1, 32'h500, 1'b0);
        tests_run++; if (o_id_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_nobypass got %0b want 0", o_id_valid); end
        step();
        drive(1'b0, 32'h0, 1'b0);
        tests_run++; if (o_id_pc !== 32'h500 || o_count !== 3'd1) begin tests_failed++; $display("FAIL areset_push got %h/%0d want 500/1", o_id_pc, o_count); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_full();
        test_back_to_back();
        test_bubbles();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
